// File: rtl/packet_stats_pkg.sv
// Shared types and arithmetic helpers for the packet statistics reducer.
package packet_stats_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } stats_state_t;

  // Widest operand the saturating adder handles; callers zero-extend into it.
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] value;
  } sat_res_t;

  // Unsigned add clamped to 'limit'; ovf flags that the true sum exceeded it.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                       input logic [SAT_MAX_W-1:0] b,
                                       input logic [SAT_MAX_W-1:0] limit);
    logic [SAT_MAX_W:0] full;
    sat_res_t           r;
    full = {1'b0, a} + {1'b0, b};
    if (full > {1'b0, limit}) begin
      r.ovf   = 1'b1;
      r.value = limit;
    end else begin
      r.ovf   = 1'b0;
      r.value = full[SAT_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/packet_stats_acc.sv
// Per-packet accumulators (length, sum, max, overflow). Exposes the
// post-beat values combinationally so the parent can capture a record that
// already includes the closing beat.
module packet_stats_acc
  import packet_stats_pkg::*;
#(
  parameter int width     = 8,
  parameter int len_width = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       accumulate,
  input  logic [width-1:0]           data,
  output logic [len_width-1:0]       len_nxt,
  output logic [width+len_width-1:0] sum_nxt,
  output logic [width-1:0]           max_nxt,
  output logic                       ovf_nxt
);

  localparam int sum_w = width + len_width;
  localparam logic [SAT_MAX_W-1:0] len_limit = SAT_MAX_W'({len_width{1'b1}});
  localparam logic [SAT_MAX_W-1:0] sum_limit = SAT_MAX_W'({sum_w{1'b1}});

  logic [len_width-1:0] len_q;
  logic [sum_w-1:0]     sum_q;
  logic [width-1:0]     max_q;
  logic                 ovf_q;
  sat_res_t             len_add;
  sat_res_t             sum_add;
  logic                 unused_hi;

  // Bits above the clamp limit are always zero after saturation.
  assign unused_hi = ^{len_add.value[SAT_MAX_W-1:len_width],
                       sum_add.value[SAT_MAX_W-1:sum_w]};

  // Post-beat values: fresh start on load, saturating update otherwise.
  always_comb begin
    len_add = sat_add(SAT_MAX_W'(len_q), SAT_MAX_W'(1), len_limit);
    sum_add = sat_add(SAT_MAX_W'(sum_q), SAT_MAX_W'(data), sum_limit);
    if (load) begin
      len_nxt = len_width'(1);
      sum_nxt = sum_w'(data);
      max_nxt = data;
      ovf_nxt = 1'b0;
    end else begin
      len_nxt = len_add.value[len_width-1:0];
      sum_nxt = sum_add.value[sum_w-1:0];
      max_nxt = (data > max_q) ? data : max_q;
      ovf_nxt = ovf_q | len_add.ovf | sum_add.ovf;
    end
  end

  // Accumulator registers advance only on accepted beats.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_q <= '0;
      sum_q <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
    end else if (load || accumulate) begin
      len_q <= len_nxt;
      sum_q <= sum_nxt;
      max_q <= max_nxt;
      ovf_q <= ovf_nxt;
    end
  end

endmodule

// File: rtl/packet_stats_from_last.sv
// Reduces a valid/last beat stream to one registered summary record per
// packet, emitted the cycle after the last beat.
//
// state | meaning
// IDLE  | between packets; next valid beat starts a new packet
// ACCUM | inside a packet; beats fold into the accumulators
module packet_stats_from_last
  import packet_stats_pkg::*;
#(
  parameter int width     = 8,
  parameter int len_width = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       up_valid,
  input  logic                       up_last,
  input  logic [width-1:0]           up_data,
  output logic                       down_valid,
  output logic [len_width-1:0]       down_len,
  output logic [width+len_width-1:0] down_sum,
  output logic [width-1:0]           down_max,
  output logic                       down_overflow
);

  stats_state_t                 state_q;
  stats_state_t                 state_d;
  logic                         load;
  logic                         accumulate;
  logic                         emit;
  logic [len_width-1:0]         len_nxt;
  logic [width+len_width-1:0]   sum_nxt;
  logic [width-1:0]             max_nxt;
  logic                         ovf_nxt;

  packet_stats_acc #(
    .width     (width),
    .len_width (len_width)
  ) u_acc (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .accumulate (accumulate),
    .data       (up_data),
    .len_nxt    (len_nxt),
    .sum_nxt    (sum_nxt),
    .max_nxt    (max_nxt),
    .ovf_nxt    (ovf_nxt)
  );

  // Next-state and accumulator control; bubbles leave everything unchanged.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    accumulate = 1'b0;
    emit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (up_valid) begin
          load = 1'b1;
          if (up_last) emit    = 1'b1;
          else         state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (up_valid) begin
          accumulate = 1'b1;
          if (up_last) begin
            emit    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Output record: one-cycle valid pulse, fields hold until the next record.
  always_ff @(posedge clock) begin
    if (reset) begin
      down_valid    <= 1'b0;
      down_len      <= '0;
      down_sum      <= '0;
      down_max      <= '0;
      down_overflow <= 1'b0;
    end else begin
      down_valid <= emit;
      if (emit) begin
        down_len      <= len_nxt;
        down_sum      <= sum_nxt;
        down_max      <= max_nxt;
        down_overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_packet_stats_from_last.sv
// Bench for packet_stats_from_last: a default instance (8/8) and a narrow
// length instance (8/2) share one stimulus stream and are compared against a
// queue-based packet model, plus a hand-written vector table.
module tb_packet_stats_from_last;

  logic        clock;
  logic        reset;
  logic        up_valid;
  logic        up_last;
  logic [7:0]  up_data;

  logic        a_valid;
  logic [7:0]  a_len;
  logic [15:0] a_sum;
  logic [7:0]  a_max;
  logic        a_ovf;

  logic        b_valid;
  logic [1:0]  b_len;
  logic [9:0]  b_sum;
  logic [7:0]  b_max;
  logic        b_ovf;

  int n_checks = 0;
  int n_errors = 0;

  packet_stats_from_last dut_a (
    .clock(clock), .reset(reset), .up_valid(up_valid), .up_last(up_last),
    .up_data(up_data), .down_valid(a_valid), .down_len(a_len),
    .down_sum(a_sum), .down_max(a_max), .down_overflow(a_ovf)
  );

  packet_stats_from_last #(.width(8), .len_width(2)) dut_b (
    .clock(clock), .reset(reset), .up_valid(up_valid), .up_last(up_last),
    .up_data(up_data), .down_valid(b_valid), .down_len(b_len),
    .down_sum(b_sum), .down_max(b_max), .down_overflow(b_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: collect beats of the open packet, summarize on last.
  typedef struct {
    bit              valid;
    longint unsigned len;
    longint unsigned sum;
    longint unsigned mx;
    bit              ovf;
  } rec_t;

  int unsigned pkt_q[$];
  rec_t exp_a;
  rec_t exp_b;

  function automatic rec_t summarize(input int unsigned beats[$], input int lw);
    rec_t r;
    longint unsigned total = 0;
    longint unsigned mx = 0;
    longint unsigned len_max = (longint'(1) << lw) - 1;
    longint unsigned sum_max = (longint'(1) << (8 + lw)) - 1;
    longint unsigned n = beats.size();
    foreach (beats[i]) begin
      total += beats[i];
      if (beats[i] > mx) mx = beats[i];
    end
    r.valid = 1'b1;
    r.len   = (n > len_max) ? len_max : n;
    r.sum   = (total > sum_max) ? sum_max : total;
    r.mx    = mx;
    r.ovf   = (n > len_max) || (total > sum_max);
    return r;
  endfunction

  task automatic model_step(input bit rst, input bit v, input bit l, input int unsigned d);
    if (rst) begin
      exp_a = '{0, 0, 0, 0, 0};
      exp_b = '{0, 0, 0, 0, 0};
      pkt_q.delete();
    end else begin
      exp_a.valid = 1'b0;
      exp_b.valid = 1'b0;
      if (v) begin
        pkt_q.push_back(d);
        if (l) begin
          exp_a = summarize(pkt_q, 8);
          exp_b = summarize(pkt_q, 2);
          pkt_q.delete();
        end
      end
    end
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_model();
    check("a.valid", a_valid, exp_a.valid);
    check("a.len",   a_len,   exp_a.len);
    check("a.sum",   a_sum,   exp_a.sum);
    check("a.max",   a_max,   exp_a.mx);
    check("a.ovf",   a_ovf,   exp_a.ovf);
    check("b.valid", b_valid, exp_b.valid);
    check("b.len",   b_len,   exp_b.len);
    check("b.sum",   b_sum,   exp_b.sum);
    check("b.max",   b_max,   exp_b.mx);
    check("b.ovf",   b_ovf,   exp_b.ovf);
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after rising.
  task automatic cycle(input bit rst, input bit v, input bit l, input int unsigned d);
    @(negedge clock);
    reset    = rst;
    up_valid = v;
    up_last  = l;
    up_data  = d[7:0];
    model_step(rst, v, l, d);
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic check_b(input string tag, input bit v, input int unsigned len,
                         input int unsigned sum, input int unsigned mx, input bit ovf);
    check({tag, ".valid"}, b_valid, v);
    check({tag, ".len"},   b_len,   len);
    check({tag, ".sum"},   b_sum,   sum);
    check({tag, ".max"},   b_max,   mx);
    check({tag, ".ovf"},   b_ovf,   ovf);
  endtask

  // Hand-derived vectors for the default instance.
  typedef struct {
    bit          rst;
    bit          v;
    bit          l;
    int unsigned d;
    bit          ev;
    int unsigned elen;
    int unsigned esum;
    int unsigned emax;
    bit          eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_row(input bit rst, input bit v, input bit l, input int unsigned d,
                                  input bit ev, input int unsigned elen, input int unsigned esum,
                                  input int unsigned emax, input bit eovf);
    vec_t r;
    r = '{rst, v, l, d, ev, elen, esum, emax, eovf};
    tbl.push_back(r);
  endfunction

  initial begin
    reset    = 1'b1;
    up_valid = 1'b0;
    up_last  = 1'b0;
    up_data  = '0;
    exp_a    = '{0, 0, 0, 0, 0};
    exp_b    = '{0, 0, 0, 0, 0};

    // reset, then 3-beat packet 5,9,2
    add_row(1, 0, 0, 0,   0, 0, 0, 0, 0);
    add_row(0, 0, 0, 0,   0, 0, 0, 0, 0);
    add_row(0, 1, 0, 5,   0, 0, 0, 0, 0);
    add_row(0, 1, 0, 9,   0, 0, 0, 0, 0);
    add_row(0, 1, 1, 2,   1, 3, 16, 9, 0);
    add_row(0, 0, 0, 0,   0, 3, 16, 9, 0);
    // single beat 200, held through 10 idle cycles
    add_row(0, 1, 1, 200, 1, 1, 200, 200, 0);
    for (int i = 0; i < 10; i++) add_row(0, 0, 0, 0, 0, 1, 200, 200, 0);
    // 1, 2, three bubbles with last high and junk data, then 3
    add_row(0, 1, 0, 1,   0, 1, 200, 200, 0);
    add_row(0, 1, 0, 2,   0, 1, 200, 200, 0);
    for (int i = 0; i < 3; i++) add_row(0, 0, 1, $urandom_range(0, 255), 0, 1, 200, 200, 0);
    add_row(0, 1, 1, 3,   1, 3, 6, 3, 0);
    // back-to-back: packet 3,7 then single beat 4
    add_row(0, 1, 0, 3,   0, 3, 6, 3, 0);
    add_row(0, 1, 1, 7,   1, 2, 10, 7, 0);
    add_row(0, 1, 1, 4,   1, 1, 4, 4, 0);
    add_row(0, 0, 0, 0,   0, 1, 4, 4, 0);
    // reset after 2 beats, reset also wins over a last beat, then 1-beat packet of 1
    add_row(0, 1, 0, 50,  0, 1, 4, 4, 0);
    add_row(0, 1, 0, 60,  0, 1, 4, 4, 0);
    add_row(1, 1, 1, 70,  0, 0, 0, 0, 0);
    add_row(0, 1, 1, 1,   1, 1, 1, 1, 0);
    add_row(0, 0, 0, 0,   0, 1, 1, 1, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].d);
      check($sformatf("tbl[%0d].valid", i), a_valid, tbl[i].ev);
      check($sformatf("tbl[%0d].len", i),   a_len,   tbl[i].elen);
      check($sformatf("tbl[%0d].sum", i),   a_sum,   tbl[i].esum);
      check($sformatf("tbl[%0d].max", i),   a_max,   tbl[i].emax);
      check($sformatf("tbl[%0d].ovf", i),   a_ovf,   tbl[i].eovf);
    end

    // narrow instance: 3 x 255 fits exactly, 5 x 255 saturates, next packet clean
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, 255);
    cycle(0, 1, 1, 255);
    check_b("len2_exact", 1, 3, 765, 255, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 255);
    cycle(0, 1, 1, 255);
    check_b("len2_sat", 1, 3, 1023, 255, 1);
    cycle(0, 1, 1, 10);
    check_b("len2_after", 1, 1, 10, 10, 0);

    // default instance length boundary: 255 beats fit, 256 overflow
    for (int i = 0; i < 254; i++) cycle(0, 1, 0, 1);
    cycle(0, 1, 1, 1);
    check("len255.len", a_len, 255);
    check("len255.ovf", a_ovf, 0);
    for (int i = 0; i < 255; i++) cycle(0, 1, 0, 1);
    cycle(0, 1, 1, 1);
    check("len256.len", a_len, 255);
    check("len256.sum", a_sum, 256);
    check("len256.ovf", a_ovf, 1);

    // random short packets with occasional reset
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255));
    end

    // random long packets to reach length saturation
    for (int i = 0; i < 1500; i++) begin
      cycle(1'b0,
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 399) == 0),
            ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255));
    end

    cycle(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
